// File: rtl/hash_ti_pkg.sv
// Shared constants, state encoding and the xorshift64 step for the Ascon TI hash front end.
package hash_ti_pkg;

  localparam int N_LANES = 8;
  localparam int SH_A    = 13;
  localparam int SH_B    = 7;
  localparam int SH_C    = 17;

  // Lanes 0..6 feed r0..r6, lane 7 is the mask lane.
  localparam logic [N_LANES-1:0][63:0] LANE_K = {
    64'h589965CC75374CC3, 64'h8EBC6AF09C88C6E3,
    64'hE7037ED1A0B428DB, 64'hA0761D6478BD642F,
    64'hD6E8FEB86659FD93, 64'h94D049BB133111EB,
    64'hBF58476D1CE4E5B9, 64'h9E3779B97F4A7C15
  };

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_MASK1   = 3'd1,
    ST_MASK2   = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_HOLD    = 3'd5,
    ST_RELEASE = 3'd6
  } state_t;

  function automatic logic [63:0] xorshift64_next(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

endpackage

// File: rtl/xorshift64_lane.sv
// One free-running xorshift64 lane; reseeding never lands on the all-zero lock-up state.
module xorshift64_lane
  import hash_ti_pkg::*;
#(
  parameter logic [63:0] K = 64'h0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seed,
  input  logic        load,
  output logic [63:0] state
);

  logic [63:0] load_val_s;
  logic [63:0] next_s;

  // Next lane value: seeded value (zero replaced by K) or one xorshift step
  always_comb begin
    load_val_s = seed ^ K;
    if (load) begin
      if (load_val_s == 64'd0) begin
        next_s = K;
      end else begin
        next_s = load_val_s;
      end
    end else begin
      next_s = xorshift64_next(state);
    end
  end

  // Lane state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= K;
    end else begin
      state <= next_s;
    end
  end

endmodule

// File: rtl/hash_msg_loader.sv
// Byte-stream message assembler, mask/randomness source and start sequencer
// for the threshold-implementation Ascon hash core.
module hash_msg_loader
  import hash_ti_pkg::*;
#(
  parameter int Y = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  input  logic [63:0]   seed,
  input  logic          seed_load,
  output logic [Y-1:0]  message,
  output logic [Y-1:0]  random_m1,
  output logic [Y-1:0]  random_m2,
  output logic [63:0]   r0,
  output logic [63:0]   r1,
  output logic [63:0]   r2,
  output logic [63:0]   r3,
  output logic [63:0]   r4,
  output logic [63:0]   r5,
  output logic [63:0]   r6,
  output logic          core_start,
  input  logic          core_ready,
  output logic          busy,
  input  logic          hash_ack,
  output logic          err
);

  localparam int NB = Y / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  if (((Y % 8) != 0) || (Y < 8) || (Y > 64)) begin : g_bad_y
    $fatal(1, "hash_msg_loader: Y must be a multiple of 8 in 8..64");
  end

  logic [N_LANES-1:0][63:0] lane_s;
  logic [Y-1:0]             mask_word_s;
  state_t                   state_r;
  state_t                   next_state_s;
  logic [CW-1:0]            cnt_r;
  logic                     beat_s;
  logic                     last_beat_s;
  logic                     frame_err_s;
  logic                     core_start_s;
  logic                     busy_s;
  logic                     s_ready_s;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    xorshift64_lane #(.K(LANE_K[i])) u_lane (
      .clk   (clk),
      .rst   (rst),
      .seed  (seed),
      .load  (seed_load),
      .state (lane_s[i])
    );
  end

  assign r0 = lane_s[0];
  assign r1 = lane_s[1];
  assign r2 = lane_s[2];
  assign r3 = lane_s[3];
  assign r4 = lane_s[4];
  assign r5 = lane_s[5];
  assign r6 = lane_s[6];
  assign mask_word_s = Y'(lane_s[7] >> (64 - Y));

  assign beat_s      = s_valid & s_ready;
  assign last_beat_s = (cnt_r == LAST_CNT);
  // A beat is malformed when s_last disagrees with the byte position.
  assign frame_err_s = beat_s & (s_last ^ last_beat_s);

  // FSM state and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_COLLECT;
      core_start <= 1'b0;
      busy       <= 1'b0;
      s_ready    <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      core_start <= core_start_s;
      busy       <= busy_s;
      s_ready    <= s_ready_s;
    end
  end

  // Next-state decision
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_COLLECT: begin
        if (beat_s && s_last && last_beat_s) begin
          next_state_s = ST_MASK1;
        end else begin
          next_state_s = ST_COLLECT;
        end
      end
      ST_MASK1:   next_state_s = ST_MASK2;
      ST_MASK2:   next_state_s = ST_START;
      ST_START:   next_state_s = ST_WAIT;
      ST_WAIT:    next_state_s = core_ready ? ST_HOLD : ST_WAIT;
      ST_HOLD:    next_state_s = hash_ack ? ST_RELEASE : ST_HOLD;
      ST_RELEASE: next_state_s = ST_COLLECT;
      default:    next_state_s = ST_COLLECT;
    endcase
  end

  // Control outputs decoded from the next state so they register alongside it
  always_comb begin
    core_start_s = 1'b0;
    busy_s       = 1'b0;
    s_ready_s    = 1'b0;
    case (next_state_s)
      ST_COLLECT: s_ready_s = 1'b1;
      ST_START, ST_RELEASE: begin
        core_start_s = 1'b1;
        busy_s       = 1'b1;
      end
      ST_WAIT, ST_HOLD: busy_s = 1'b1;
      default: s_ready_s = 1'b0;
    endcase
  end

  // Byte assembly, framing check and mask share capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      message   <= '0;
      random_m1 <= '0;
      random_m2 <= '0;
      err       <= 1'b0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (frame_err_s) begin
            err     <= 1'b1;
            cnt_r   <= '0;
            message <= '0;
          end else if (beat_s) begin
            for (int b = 0; b < NB; b++) begin
              if (cnt_r == CW'(b)) begin
                message[Y-1-8*b -: 8] <= s_data;
              end
            end
            cnt_r <= last_beat_s ? '0 : cnt_r + CW'(1);
          end
        end
        ST_MASK1:   random_m1 <= mask_word_s;
        ST_MASK2:   random_m2 <= mask_word_s;
        ST_RELEASE: begin
          message <= '0;
          cnt_r   <= '0;
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule
